// File: rtl/generic_sequential_divider.sv
// generic_sequential_divider: restoring shift/subtract divider, one quotient bit per clock.
// Define GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN for two's-complement truncating division.
module generic_sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             START,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             VALID,
  output logic             DIVZERO
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, dvd_q, dvd_d, dsr_q, dsr_d, q_q, q_d, r_q, r_d;
  logic dz_q, dz_d, valid_q, valid_d;
  logic [WIDTH:0] trial;
  // rem_q < dsr_q always holds, so the shifted remainder fits and trial[WIDTH] is the borrow
  assign trial = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
  logic sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] ma, mb;
  assign ma = A[WIDTH-1] ? -A : A;
  assign mb = B[WIDTH-1] ? -B : B;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    valid_d = 1'b0;
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
`endif
    case (state_q)
      IDLE: if (START) begin
        state_d = RUN;
        rem_d   = '0;
        cnt_d   = CW'(WIDTH);
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
        dvd_d   = ma;
        dsr_d   = mb;
        sa_d    = A[WIDTH-1];
        sb_d    = B[WIDTH-1];
`else
        dvd_d   = A;
        dsr_d   = B;
`endif
      end
      RUN: begin
        rem_d   = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d   = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? FINISH : RUN;
      end
      FINISH: begin
        state_d = IDLE;
        valid_d = 1'b1;
        dz_d    = (dsr_q == '0);
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
        q_d     = (dsr_q == '0) ? '1 : (sa_q ^ sb_q) ? -dvd_q : dvd_q;
        r_d     = sa_q ? -rem_q : rem_q;
`else
        q_d     = dvd_q;
        r_d     = rem_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      valid_q <= valid_d;
    end
  end
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sa_q <= 1'b0;
      sb_q <= 1'b0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end
`endif
  assign Q       = q_q;
  assign R       = r_q;
  assign DIVZERO = dz_q;
  assign VALID   = valid_q;
  assign BUSY    = (state_q != IDLE);
endmodule

// File: tb/tb_generic_sequential_divider.sv
// tb_generic_sequential_divider: directed vector table plus back-to-back and reset-abort sequences at WIDTH=8.
module tb_generic_sequential_divider;
  localparam int W = 8;
  logic CLK = 1'b0, nRST = 1'b0, START = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic [W-1:0] Q, R;
  logic BUSY, VALID, DIVZERO;
  int nvec = 0, nerr = 0;

  generic_sequential_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .A(A), .B(B), .START(START),
    .Q(Q), .R(R), .BUSY(BUSY), .VALID(VALID), .DIVZERO(DIVZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       dz;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz, output int lat);
    @(negedge CLK);
    A = a; B = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("busy after start", BUSY, 1);
    lat = 0;
    while (!VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
    end
    q = Q; r = R; dz = DIVZERO;
  endtask

  initial begin
    logic [7:0] q, r;
    logic dz;
    int lat, vcnt;
`ifdef GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN
    tab.push_back('{8'(-100), 8'd7,     8'(-14),  8'(-2),   1'b0});
    tab.push_back('{8'(-128), 8'(-1),   8'(-128), 8'd0,     1'b0});
    tab.push_back('{8'd100,   8'(-7),   8'(-14),  8'd2,     1'b0});
    tab.push_back('{8'(-7),   8'd0,     8'hFF,    8'(-7),   1'b0 | 1'b1});
    tab.push_back('{8'd100,   8'd7,     8'd14,    8'd2,     1'b0});
    tab.push_back('{8'(-9),   8'(-4),   8'd2,     8'(-1),   1'b0});
    tab.push_back('{8'd0,     8'd5,     8'd0,     8'd0,     1'b0});
`else
    tab.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0});
    tab.push_back('{8'd200, 8'd0,   8'd255, 8'd200, 1'b1});
    tab.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0});
    tab.push_back('{8'd9,   8'd3,   8'd3,   8'd0,   1'b0});
    tab.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0});
    tab.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    tab.push_back('{8'd1,   8'd2,   8'd0,   8'd1,   1'b0});
    tab.push_back('{8'd254, 8'd15,  8'd16,  8'd14,  1'b0});
    tab.push_back('{8'd7,   8'd200, 8'd0,   8'd7,   1'b0});
    tab.push_back('{8'd128, 8'd16,  8'd8,   8'd0,   1'b0});
`endif
    #12;
    chk("reset Q", Q, 0);
    chk("reset R", R, 0);
    chk("reset BUSY", BUSY, 0);
    chk("reset VALID", VALID, 0);
    chk("reset DIVZERO", DIVZERO, 0);
    @(negedge CLK);
    nRST = 1'b1;

    foreach (tab[i]) begin
      do_op(tab[i].a, tab[i].b, q, r, dz, lat);
      chk($sformatf("vec%0d latency", i), lat, 9);
      chk($sformatf("vec%0d Q", i), q, tab[i].q);
      chk($sformatf("vec%0d R", i), r, tab[i].r);
      chk($sformatf("vec%0d DIVZERO", i), dz, tab[i].dz);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d VALID pulse width", i), VALID, 0);
      chk($sformatf("vec%0d idle after result", i), BUSY, 0);
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("hold Q", Q, tab[tab.size()-1].q);
    chk("hold R", R, tab[tab.size()-1].r);

    @(negedge CLK);
    A = 8'd255; B = 8'd1; START = 1'b1;
    @(posedge CLK); #1;
    lat = 0;
    while (!VALID && lat < 40) begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 3) begin
        A = 8'd9; B = 8'd3;
      end
    end
    chk("b2b first latency", lat, 9);
    chk("b2b first Q", Q, 255);
    chk("b2b first R", R, 0);
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!VALID && lat < 40);
    START = 1'b0;
    chk("b2b second spacing", lat, 10);
    chk("b2b second Q", Q, 3);
    chk("b2b second R", R, 0);
    @(posedge CLK); #1;
    chk("b2b no third start", BUSY, 0);

    @(negedge CLK);
    A = 8'd100; B = 8'd7; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("abort Q", Q, 0);
    chk("abort R", R, 0);
    chk("abort BUSY", BUSY, 0);
    chk("abort VALID", VALID, 0);
    chk("abort DIVZERO", DIVZERO, 0);
    @(negedge CLK);
    nRST = 1'b1;
    vcnt = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (VALID) vcnt++;
    end
    chk("no VALID after abort", vcnt, 0);
    do_op(8'd50, 8'd6, q, r, dz, lat);
    chk("post-reset latency", lat, 9);
    chk("post-reset Q", q, 8);
    chk("post-reset R", r, 2);
    chk("post-reset DIVZERO", dz, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/generic_sequential_divider.md
GENERIC_SEQUENTIAL_DIVIDER -- requirements
Module: generic_sequential_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port CLK  input  1  as its only clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port nRST  input  1  as an asynchronous, active-low reset.
REQ-004 The block SHALL have port A  input  WIDTH  carrying the dividend.
REQ-005 The block SHALL have port B  input  WIDTH  carrying the divisor.
REQ-006 The block SHALL have port START  input  1  as the request to begin a division.
REQ-007 The block SHALL have port Q  output  WIDTH  carrying the quotient, registered.
REQ-008 The block SHALL have port R  output  WIDTH  carrying the remainder, registered.
REQ-009 The block SHALL have port BUSY  output  1  indicating that a division is in progress.
REQ-010 The block SHALL have port VALID  output  1  as a one-cycle pulse marking Q, R and DIVZERO as new.
REQ-011 The block SHALL have port DIVZERO  output  1  flagging that the divisor was zero, registered with Q.

Function
REQ-012 The block SHALL implement a restoring shift/subtract divider that resolves one quotient bit per clock.
REQ-013 The state machine SHALL use states IDLE, RUN and FINISH.
REQ-014 In IDLE with START=1, the block SHALL latch A and B, clear the partial remainder, load the iteration counter with WIDTH, and go to RUN.
REQ-015 BUSY SHALL be 1 in RUN and FINISH and 0 in IDLE.
REQ-016 In each RUN cycle, the block SHALL shift {partial remainder, dividend} left by one and compute trial = remainder - divisor over WIDTH+1 bits. If the trial does not borrow, the block SHALL keep it and set the quotient bit to 1; otherwise it SHALL restore the remainder and set the bit to 0.
REQ-017 After the WIDTH-th RUN cycle the block SHALL enter FINISH; in FINISH it SHALL register Q, R and DIVZERO, pulse VALID for exactly one cycle, and return to IDLE.
REQ-018 VALID SHALL assert exactly WIDTH+1 clocks after the edge that sampled START=1; this latency SHALL be fixed and independent of the data.
REQ-019 START SHALL be ignored while BUSY=1, and the latched operands SHALL NOT change during the operation.
REQ-020 START=1 in the cycle VALID is high SHALL be accepted, because the state is already IDLE on the following edge; back-to-back throughput is one result every WIDTH+2 clocks.
REQ-021 On a division by zero (B=0), the block SHALL produce Q = all ones, R = A and DIVZERO=1, with the same latency; otherwise DIVZERO SHALL be 0.
REQ-022 Q, R and DIVZERO SHALL hold their values until the next FINISH.

Reset
REQ-023 While nRST=0, the block SHALL be in IDLE with Q=0, R=0, BUSY=0, VALID=0, DIVZERO=0 and the counter at 0.
REQ-024 A reset during RUN or FINISH SHALL abort the operation without producing a VALID pulse.
REQ-025 Reset deassertion SHALL be synchronized externally; the first START SHALL be accepted on the first edge with nRST=1.

Configuration
REQ-026 When macro GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN is defined, the block SHALL treat A and B as two's complement and use the following sign handling:
- Magnitudes are taken at START.
- The unsigned core runs on the magnitudes.
- In FINISH, Q is negated when sign(A) differs from sign(B), and R takes the sign of A (truncating division).
- The latency is unchanged.
REQ-027 When GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN is defined, the most-negative / -1 case SHALL return Q = most-negative value and R=0. The all-ones Q on divide-by-zero SHALL read as -1.
REQ-028 Without GENERIC_SEQUENTIAL_DIVIDER_SIGNED_EN, the block SHALL be unsigned only and SHALL contain no sign logic.

Verification (WIDTH=8)
REQ-029 Unsigned division: A=100, B=7, START for 1 clk -> BUSY high, then VALID pulse 9 clks later with Q=14, R=2, DIVZERO=0.
REQ-030 Divide by zero: A=200, B=0 -> VALID at 9 clks with Q=255, R=200, DIVZERO=1.
REQ-031 START ignored while busy, then back-to-back: START held high continuously with A=255, B=1, and A/B changed mid-run to 9/3 -> first result Q=255, R=0 unaffected by the change. The second operation starts on the VALID cycle and produces Q=3, R=0 10 clks after the first VALID.
REQ-032 Reset mid-operation: nRST low at clk 4 of RUN -> all outputs 0 immediately (asynchronously) and no VALID. A new START after release (A=50, B=6) gives Q=8, R=2.
REQ-033 Signed build (SIGNED_EN): A=-100, B=7 -> Q=-14, R=-2. A=-128, B=-1 -> Q=-128, R=0. A=100, B=-7 -> Q=-14, R=2. All at 9-clk latency.
REQ-034 Random check: 10k random unsigned pairs against a reference model -> every Q*B+R=A with R<B when B!=0, and zero VALID glitches.
